// File: rtl/kbd_event_queue_pkg.sv
// kbd_pkg: shared constants, field positions and FSM encoding for the keyboard event queue
//   prefixes/error bytes from the PS/2 scan-code stream, event and status bit positions,
//   handshake state type, and a helper that classifies the two error bytes.
package kbd_pkg;
  localparam logic [7:0] KBD_BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] KBD_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] KBD_ERR_00       = 8'h00;
  localparam logic [7:0] KBD_ERR_FF       = 8'hFF;
  localparam int EVT_EXT_BIT = 9;
  localparam int EVT_BRK_BIT = 8;
  localparam int ST_DROP_LSB = 24;
  localparam int ST_OVF_BIT  = 23;
  localparam int ST_ERR_BIT  = 22;
  localparam int ST_CNT_LSB  = 8;
  typedef enum logic {KBD_IDLE, KBD_ACK} kbd_state_e;
  function automatic logic kbd_is_err(input logic [7:0] b);
    return b == KBD_ERR_00 || b == KBD_ERR_FF;
  endfunction
endpackage

// File: rtl/kbd_event_queue_if.sv
// kbd_event_queue_if: PS/2 receiver handshake plus CPU MMIO event/status signals
//   ps2_data/ps2_ready/ps2_nextdata_n : receiver byte handshake
//   cpu_pop/cpu_clear                 : one-cycle CPU strobes
//   evt_valid/evt_data/status         : queue head and status word
//   slave = the queue controller, master = the side driving receiver bytes and CPU strobes
interface kbd_event_queue_if;
  logic [7:0]  ps2_data;
  logic        ps2_ready;
  logic        ps2_nextdata_n;
  logic        cpu_pop;
  logic        cpu_clear;
  logic        evt_valid;
  logic [9:0]  evt_data;
  logic [31:0] status;
  modport master(output ps2_data, ps2_ready, cpu_pop, cpu_clear,
                 input ps2_nextdata_n, evt_valid, evt_data, status);
  modport slave(input ps2_data, ps2_ready, cpu_pop, cpu_clear,
                output ps2_nextdata_n, evt_valid, evt_data, status);
endinterface

// File: rtl/kbd_event_queue_fifo.sv
// kbd_fifo: circular show-ahead buffer with push/pop/clear and full/empty/count
//   clk, clrn (async active-low), clr (sync flush), push/wr_data, pop/rd_data (= mem[head]),
//   full, empty, count = tail - head
module kbd_fifo #(
  parameter int DEPTH = 32,
  parameter int W = 10
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] head, tail;
  logic [W-1:0] mem [DEPTH];
  logic pop_ok, push_ok;
  always_comb begin
    empty = head == tail;
    full = head[AW] != tail[AW] && head[AW-1:0] == tail[AW-1:0];
    count = tail - head;
    pop_ok = pop && !empty;
    // a pop in the same cycle frees the slot, so a push into a full buffer is still accepted
    push_ok = push && (!full || pop_ok);
    rd_data = mem[head[AW-1:0]];
  end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      head <= '0;
      tail <= '0;
    end else if (clr) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (pop_ok) head <= head + 1'b1;
      if (push_ok) tail <= tail + 1'b1;
    end
  always_ff @(posedge clk)
    if (push_ok && !clr) mem[tail[AW-1:0]] <= wr_data;
endmodule

// File: rtl/kbd_event_queue.sv
// kbd_event_queue: PS/2 byte handshake, F0/E0 prefix decode, repeat filter and CPU event FIFO
//   clk  : CLK50 system clock
//   clrn : asynchronous active-low reset
//   bus  : kbd_event_queue_if.slave (receiver handshake, cpu_pop/cpu_clear, evt_valid/evt_data/status)
//   Optional feature macro KBD_BREAK_EVENT_EN: when defined, release events are queued with brk=1;
//   otherwise releases only update the repeat filter and never occupy the FIFO.
module kbd_event_queue
  import kbd_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int REPEAT_FILTER = 1
) (
  input logic clk,
  input logic clrn,
  kbd_event_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  kbd_state_e state, state_n;
  logic [7:0] byte_q, drop_cnt;
  logic brk_pend, ext_pend, err, ovf;
  logic [8:0] last_make, key;
  logic ack, dec, is_brk, is_ext, is_bad, is_code;
  logic make_ev, brk_ev, rpt_hit, push, pop, drop, full, empty;
  logic [9:0] wr_data, rd_data;
  logic [AW:0] count;
  always_comb begin
    ack = state == KBD_ACK;
    state_n = ack ? KBD_IDLE : (bus.ps2_ready ? KBD_ACK : KBD_IDLE);
    // a clear in the ACK cycle still strobes the receiver but throws the byte away
    dec = ack && !bus.cpu_clear;
    is_brk = byte_q == KBD_BREAK_PREFIX;
    is_ext = byte_q == KBD_EXT_PREFIX;
    is_bad = kbd_is_err(byte_q);
    is_code = !(is_brk || is_ext || is_bad);
    key = {ext_pend, byte_q};
    make_ev = dec && is_code && !brk_pend;
    brk_ev = dec && is_code && brk_pend;
    rpt_hit = REPEAT_FILTER != 0 && key == last_make;
`ifdef KBD_BREAK_EVENT_EN
    push = (make_ev && !rpt_hit) || brk_ev;
`else
    push = make_ev && !rpt_hit;
`endif
    pop = bus.cpu_pop && !bus.cpu_clear;
    drop = push && full && !pop;
    wr_data = '0;
    wr_data[EVT_EXT_BIT] = ext_pend;
    wr_data[EVT_BRK_BIT] = brk_pend;
    wr_data[7:0] = byte_q;
  end
  kbd_fifo #(.DEPTH(DEPTH), .W(10)) u_fifo (
    .clk(clk),
    .clrn(clrn),
    .clr(bus.cpu_clear),
    .push(push),
    .pop(pop),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // strobe is decoded from the state flop so an async reset releases it immediately
  assign bus.ps2_nextdata_n = !ack;
  assign bus.evt_valid = !empty;
  assign bus.evt_data = empty ? '0 : rd_data;
  always_comb begin
    bus.status = '0;
    bus.status[ST_DROP_LSB +: 8] = drop_cnt;
    bus.status[ST_OVF_BIT] = ovf;
    bus.status[ST_ERR_BIT] = err;
    bus.status[ST_CNT_LSB +: 8] = 8'(count);
  end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      state <= KBD_IDLE;
      byte_q <= '0;
      brk_pend <= 1'b0;
      ext_pend <= 1'b0;
      err <= 1'b0;
      ovf <= 1'b0;
      drop_cnt <= '0;
      last_make <= '0;
    end else begin
      state <= state_n;
      if (state == KBD_IDLE && bus.ps2_ready) byte_q <= bus.ps2_data;
      if (bus.cpu_clear) begin
        brk_pend <= 1'b0;
        ext_pend <= 1'b0;
        err <= 1'b0;
        ovf <= 1'b0;
        drop_cnt <= '0;
        last_make <= '0;
      end else begin
        if (dec && is_brk) brk_pend <= 1'b1;
        else if (dec && is_ext) ext_pend <= 1'b1;
        else if (dec) begin
          brk_pend <= 1'b0;
          ext_pend <= 1'b0;
        end
        if (dec && is_bad) err <= 1'b1;
        // a code of 0 is an error byte, so last_make==0 never matches a real key
        if (make_ev) last_make <= key;
        else if (brk_ev && key == last_make) last_make <= '0;
        if (drop) begin
          ovf <= 1'b1;
          drop_cnt <= drop_cnt == 8'hFF ? drop_cnt : drop_cnt + 8'd1;
        end
      end
    end
endmodule
